// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types and constants for the RPN stack sequencer.
//   - op_e    : 3-bit operator opcodes carried in TOK_DAT[2:0]
//   - state_e : sequencer FSM states
//   - ERR_*   : ERR_CODE values
//   - DW      : stack data width
// Optional feature macro: RPN_DIV_EN (opcode 111 = unsigned divide).
package rpn_pkg;

  localparam int DW = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_DROP2 = 3'd6,
    OP_DIV   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_OPND, S_POP_B, S_GAP, S_POP_A, S_EXEC, S_PUSH_RES, S_DRAIN
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

`ifdef RPN_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Without the divider, opcode 111 is rejected at decode.
  function automatic logic op_legal(input op_e op);
    return DIV_EN || (op != OP_DIV);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: combinational ALU for the RPN sequencer, r = a op b (mod 256).
//   a_i, b_i : operands (b is the value that was on top of the stack)
//   op_i     : opcode (rpn_pkg::op_e encoding)
//   r_o      : result (0 for DROP2 / divide-by-zero)
//   div0_o   : divide by zero detected (only when RPN_DIV_EN is defined)
// Macro RPN_DIV_EN: when undefined no divider logic is built.
module rpn_alu
  import rpn_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [2:0]    op_i,
  output logic [DW-1:0] r_o,
  output logic          div0_o
);

  always_comb begin
    r_o    = '0;
    div0_o = 1'b0;
    case (op_e'(op_i))
      OP_ADD: r_o = a_i + b_i;
      OP_SUB: r_o = a_i - b_i;
      OP_MUL: r_o = a_i * b_i;
      OP_AND: r_o = a_i & b_i;
      OP_OR:  r_o = a_i | b_i;
      OP_XOR: r_o = a_i ^ b_i;
      OP_DIV: begin
`ifdef RPN_DIV_EN
        if (b_i == '0) div0_o = 1'b1;
        else           r_o    = a_i / b_i;
`endif
      end
      default: r_o = '0;
    endcase
  end

endmodule

// File: rtl/rpn_ctrl.sv
// rpn_ctrl: token-driven sequencer, sole master of the operand stack.
//   CLK, RST           : clock, async active-high reset (also resets the stack)
//   TOK_STB/OP/DAT/ACK : token handshake; operand value or opcode in DAT[2:0]
//   CLR                : drain request, honoured in IDLE with priority over tokens
//   PUSH_STB/DAT       : push pulse + data to the stack (PUSH_ACK ignored)
//   POP_STB/DAT        : stack non-empty / current top (combinational)
//   POP_ACK            : pop pulse to the stack
//   RES_DAT/RES_VLD    : last result (held) and its one-cycle update pulse
//   ERR/ERR_CODE       : sticky error flag and first error code
//   LEVEL              : mirrored stack depth 0..DEPTH
// Macro RPN_DIV_EN enables opcode 111 as unsigned A/B.
module rpn_ctrl
  import rpn_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          TOK_STB,
  input  logic          TOK_OP,
  input  logic [DW-1:0] TOK_DAT,
  output logic          TOK_ACK,
  input  logic          CLR,
  output logic          PUSH_STB,
  output logic [DW-1:0] PUSH_DAT,
  input  logic          PUSH_ACK,
  input  logic          POP_STB,
  input  logic [DW-1:0] POP_DAT,
  output logic          POP_ACK,
  output logic [DW-1:0] RES_DAT,
  output logic          RES_VLD,
  output logic          ERR,
  output logic [1:0]    ERR_CODE,
  output logic [4:0]    LEVEL
);

  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  state_e        state_q, state_d;
  logic [4:0]    lvl_q, lvl_d;
  logic [DW-1:0] dat_q, dat_d;   // operand to push, or result to push
  logic [DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  op_e           op_q, op_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          ph_q, ph_d;     // DRAIN phase: 0 = pop slot, 1 = gap slot
  logic          raise;
  logic [1:0]    raise_code;
  logic [DW-1:0] alu_r;
  logic          alu_div0;

  // Push handshake is fire-and-forget.
  logic unused_push_ack;
  assign unused_push_ack = PUSH_ACK;

  rpn_alu u_alu (.a_i(a_q), .b_i(b_q), .op_i(op_q), .r_o(alu_r), .div0_o(alu_div0));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      lvl_q   <= '0;
      dat_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_ADD;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      dat_q   <= dat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    dat_d      = dat_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    op_d       = op_q;
    err_d      = err_q;
    code_d     = code_q;
    ph_d       = ph_q;
    raise      = 1'b0;
    raise_code = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        if (CLR) begin
          state_d = S_DRAIN;
          ph_d    = 1'b0;
        end else if (TOK_STB) begin
          if (!TOK_OP) begin
            if (lvl_q == DEPTH_L) begin
              raise = 1'b1; raise_code = ERR_OVER;
            end else begin
              dat_d   = TOK_DAT;
              state_d = S_PUSH_OPND;
            end
          end else begin
            op_d = op_e'(TOK_DAT[2:0]);
            if (lvl_q < 5'd2) begin
              raise = 1'b1; raise_code = ERR_UNDER;
            end else if (!op_legal(op_e'(TOK_DAT[2:0]))) begin
              raise = 1'b1; raise_code = ERR_ILLEGAL;
            end else begin
              state_d = S_POP_B;
            end
          end
        end
      end
      S_PUSH_OPND: begin
        lvl_d   = lvl_q + 5'd1;
        state_d = S_IDLE;
      end
      S_POP_B: begin
        b_d     = POP_DAT;
        lvl_d   = lvl_q - 5'd1;
        state_d = S_GAP;
      end
      // Lets the stack's top-of-stack read settle after the first pop.
      S_GAP: state_d = S_POP_A;
      S_POP_A: begin
        a_d     = POP_DAT;
        lvl_d   = lvl_q - 5'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (alu_div0) begin
          raise = 1'b1; raise_code = ERR_ILLEGAL;
          state_d = S_IDLE;
        end else if (op_q == OP_DROP2) begin
          state_d = S_IDLE;
        end else begin
          dat_d   = alu_r;
          res_d   = alu_r;  // valid on RES_DAT in the same cycle as RES_VLD
          state_d = S_PUSH_RES;
        end
      end
      S_PUSH_RES: begin
        lvl_d   = lvl_q + 5'd1;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        // Exit is only checked in a pop slot, giving 2*LEVEL+1 cycles.
        if (!ph_q) begin
          if (lvl_q == '0) begin
            err_d   = 1'b0;
            code_d  = ERR_NONE;
            state_d = S_IDLE;
          end else begin
            lvl_d = lvl_q - 5'd1;
            ph_d  = 1'b1;
          end
        end else begin
          ph_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // First error wins; later errors leave the code untouched.
    if (raise && !err_q) begin
      err_d  = 1'b1;
      code_d = raise_code;
    end
  end

  assign TOK_ACK  = (state_q == S_IDLE) && TOK_STB && !CLR;
  assign PUSH_STB = (state_q == S_PUSH_OPND) || (state_q == S_PUSH_RES);
  assign PUSH_DAT = PUSH_STB ? dat_q : '0;
  assign POP_ACK  = (state_q == S_POP_B) || (state_q == S_POP_A) ||
                    ((state_q == S_DRAIN) && !ph_q && (lvl_q != '0));
  assign RES_VLD  = (state_q == S_PUSH_RES);
  assign RES_DAT  = res_q;
  assign ERR      = err_q;
  assign ERR_CODE = code_q;
  assign LEVEL    = lvl_q;

  a_pop_nonempty: assert property (@(posedge CLK) disable iff (RST) POP_ACK |-> POP_STB);
  a_push_pop_excl: assert property (@(posedge CLK) disable iff (RST) !(PUSH_STB && POP_ACK));

endmodule

// File: tb/tb_rpn_ctrl.sv
module tb_rpn_ctrl;

  logic       CLK = 1'b0, RST = 1'b1;
  logic       TOK_STB = 1'b0, TOK_OP = 1'b0, CLR = 1'b0;
  logic [7:0] TOK_DAT = 8'h00;
  logic       TOK_ACK, PUSH_STB, POP_ACK, RES_VLD, ERR, POP_STB;
  logic [7:0] PUSH_DAT, POP_DAT, RES_DAT;
  logic [1:0] ERR_CODE;
  logic [4:0] LEVEL;

  rpn_ctrl #(.DEPTH(16)) dut (
    .CLK(CLK), .RST(RST), .TOK_STB(TOK_STB), .TOK_OP(TOK_OP), .TOK_DAT(TOK_DAT),
    .TOK_ACK(TOK_ACK), .CLR(CLR), .PUSH_STB(PUSH_STB), .PUSH_DAT(PUSH_DAT),
    .PUSH_ACK(1'b1), .POP_STB(POP_STB), .POP_DAT(POP_DAT), .POP_ACK(POP_ACK),
    .RES_DAT(RES_DAT), .RES_VLD(RES_VLD), .ERR(ERR), .ERR_CODE(ERR_CODE), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  // Stack model
  logic [7:0] mem [16];
  logic [4:0] sp;
  always @(posedge CLK or posedge RST) begin
    if (RST) sp <= 5'd0;
    else if (PUSH_STB) begin mem[sp[3:0]] <= PUSH_DAT; sp <= sp + 5'd1; end
    else if (POP_ACK) sp <= sp - 5'd1;
  end
  assign POP_STB = (sp != 5'd0);
  assign POP_DAT = (sp != 5'd0) ? mem[sp[3:0] - 4'd1] : 8'h00;

  // Scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int vec = 0, bad = 0, push_cnt = 0, pop_cnt = 0;

  always @(negedge CLK) begin
    if (PUSH_STB) push_cnt++;
    if (POP_ACK)  pop_cnt++;
    if (RES_VLD) begin
      vec++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL res_unexpected: RES_DAT=%h, no result expected", RES_DAT);
      end else begin
        mon_exp = exp_q.pop_front();
        if (RES_DAT !== mon_exp) begin
          bad++; $display("FAIL res_dat: got %h, expected %h", RES_DAT, mon_exp);
        end
      end
    end
  end

  task automatic send_tok(input logic op, input logic [7:0] d);
    int n = 0;
    @(negedge CLK); TOK_STB = 1'b1; TOK_OP = op; TOK_DAT = d;
    #1;
    while (!TOK_ACK && n < 60) begin @(negedge CLK); #1; n++; end
    if (!TOK_ACK) begin
      vec++; bad++; $display("FAIL tok_ack_timeout: op=%0d dat=%h not accepted", op, d);
    end else begin
      @(posedge CLK); #1;
    end
    TOK_STB = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_clr();
    int n = 0;
    @(negedge CLK); CLR = 1'b1;
    @(posedge CLK); #1 CLR = 1'b0;
    while ((LEVEL != 5'd0 || ERR) && n < 100) begin @(negedge CLK); n++; end
    vec++;
    if (LEVEL !== 5'd0 || ERR !== 1'b0) begin
      bad++; $display("FAIL clr_done: LEVEL=%0d ERR=%b, expected 0/0", LEVEL, ERR);
    end
    wait_cyc(2);
  endtask

  task automatic test_reset();
    wait_cyc(3);
    vec++;
    if ({TOK_ACK, PUSH_STB, PUSH_DAT, POP_ACK, RES_DAT, RES_VLD, ERR, ERR_CODE, LEVEL} !== '0) begin
      bad++; $display("FAIL reset_outputs: PUSH=%b/%h POP=%b RES=%h/%b ERR=%b/%b LEVEL=%0d, expected all 0",
                      PUSH_STB, PUSH_DAT, POP_ACK, RES_DAT, RES_VLD, ERR, ERR_CODE, LEVEL);
    end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_add();
    send_tok(1'b0, 8'd3);
    @(negedge CLK); vec++;
    if (PUSH_STB !== 1'b1 || PUSH_DAT !== 8'd3) begin
      bad++; $display("FAIL push_opnd: PUSH_STB=%b PUSH_DAT=%h, expected 1/03", PUSH_STB, PUSH_DAT);
    end
    @(negedge CLK); vec++;
    if (LEVEL !== 5'd1) begin bad++; $display("FAIL level_1: got %0d, expected 1", LEVEL); end
    send_tok(1'b0, 8'd4);
    wait_cyc(2); vec++;
    if (LEVEL !== 5'd2) begin bad++; $display("FAIL level_2: got %0d, expected 2", LEVEL); end
    exp_q.push_back(8'd7);
    send_tok(1'b1, 8'd0);
    @(negedge CLK); vec++;
    if (POP_ACK !== 1'b1) begin bad++; $display("FAIL pop_b: POP_ACK=%b, expected 1", POP_ACK); end
    wait_cyc(3); vec++;
    if (RES_VLD !== 1'b0 || LEVEL !== 5'd0) begin
      bad++; $display("FAIL exec_cycle: RES_VLD=%b LEVEL=%0d, expected 0/0", RES_VLD, LEVEL);
    end
    @(negedge CLK); vec++;
    if (RES_VLD !== 1'b1 || PUSH_STB !== 1'b1 || PUSH_DAT !== 8'd7) begin
      bad++; $display("FAIL push_res: RES_VLD=%b PUSH=%b/%h, expected 1/1/07", RES_VLD, PUSH_STB, PUSH_DAT);
    end
    @(negedge CLK); vec++;
    if (LEVEL !== 5'd1 || POP_DAT !== 8'd7 || RES_VLD !== 1'b0) begin
      bad++; $display("FAIL add_after: LEVEL=%0d top=%h RES_VLD=%b, expected 1/07/0", LEVEL, POP_DAT, RES_VLD);
    end
  endtask

  task automatic test_sub_mul();
    do_clr();
    exp_q.push_back(8'hFD);
    send_tok(1'b0, 8'd2); send_tok(1'b0, 8'd5); send_tok(1'b1, 8'd1);
    exp_q.push_back(8'h90);
    send_tok(1'b0, 8'd200); send_tok(1'b0, 8'd2); send_tok(1'b1, 8'd2);
    wait_cyc(7); vec++;
    if (LEVEL !== 5'd2 || POP_DAT !== 8'h90 || ERR !== 1'b0) begin
      bad++; $display("FAIL sub_mul: LEVEL=%0d top=%h ERR=%b, expected 2/90/0", LEVEL, POP_DAT, ERR);
    end
  endtask

  task automatic test_underflow();
    int p;
    do_clr();
    p = pop_cnt;
    send_tok(1'b1, 8'd0);
    wait_cyc(3); vec++;
    if (ERR !== 1'b1 || ERR_CODE !== 2'b01 || pop_cnt != p || LEVEL !== 5'd0) begin
      bad++; $display("FAIL underflow: ERR=%b code=%b pops=%0d LEVEL=%0d, expected 1/01/0/0",
                      ERR, ERR_CODE, pop_cnt - p, LEVEL);
    end
  endtask

  task automatic test_err_sticky();
    exp_q.push_back(8'h0C);
    send_tok(1'b0, 8'h0F); send_tok(1'b0, 8'h3C); send_tok(1'b1, 8'd3);
    exp_q.push_back(8'h3F);
    send_tok(1'b0, 8'h33); send_tok(1'b1, 8'd4);
    exp_q.push_back(8'h6A);
    send_tok(1'b0, 8'h55); send_tok(1'b1, 8'd5);
    send_tok(1'b0, 8'h01); send_tok(1'b1, 8'd6);   // DROP2, no result
    wait_cyc(7); vec++;
    if (LEVEL !== 5'd0 || ERR !== 1'b1 || ERR_CODE !== 2'b01) begin
      bad++; $display("FAIL err_sticky: LEVEL=%0d ERR=%b code=%b, expected 0/1/01", LEVEL, ERR, ERR_CODE);
    end
  endtask

  task automatic test_clr_prio();
    @(negedge CLK); CLR = 1'b1; TOK_STB = 1'b1; TOK_OP = 1'b0; TOK_DAT = 8'h55;
    #1; vec++;
    if (TOK_ACK !== 1'b0) begin bad++; $display("FAIL clr_prio: TOK_ACK=%b, expected 0", TOK_ACK); end
    @(posedge CLK); #1 CLR = 1'b0;
    @(negedge CLK); @(negedge CLK); #1; vec++;
    if (TOK_ACK !== 1'b1 || ERR !== 1'b0 || ERR_CODE !== 2'b00) begin
      bad++; $display("FAIL clr_empty: TOK_ACK=%b ERR=%b code=%b, expected 1/0/00", TOK_ACK, ERR, ERR_CODE);
    end
    @(posedge CLK); #1 TOK_STB = 1'b0;
    wait_cyc(2); vec++;
    if (LEVEL !== 5'd1 || POP_DAT !== 8'h55) begin
      bad++; $display("FAIL clr_then_push: LEVEL=%0d top=%h, expected 1/55", LEVEL, POP_DAT);
    end
  endtask

  task automatic test_overflow();
    int p, q, n;
    do_clr();
    p = push_cnt;
    for (int i = 0; i < 17; i++) send_tok(1'b0, 8'(i + 16));
    wait_cyc(2); vec++;
    if (ERR !== 1'b1 || ERR_CODE !== 2'b10 || push_cnt - p != 16 || LEVEL !== 5'd16) begin
      bad++; $display("FAIL overflow: ERR=%b code=%b pushes=%0d LEVEL=%0d, expected 1/10/16/16",
                      ERR, ERR_CODE, push_cnt - p, LEVEL);
    end
    q = pop_cnt; n = 0;
    @(negedge CLK); CLR = 1'b1;
    @(posedge CLK); #1 CLR = 1'b0;
    while (ERR && n < 100) begin @(negedge CLK); n++; end
    vec++;
    if (n != 34 || pop_cnt - q != 16 || LEVEL !== 5'd0 || ERR_CODE !== 2'b00) begin
      bad++; $display("FAIL drain: cycles=%0d pops=%0d LEVEL=%0d code=%b, expected 34/16/0/00",
                      n, pop_cnt - q, LEVEL, ERR_CODE);
    end
    wait_cyc(2);
  endtask

  task automatic test_div();
    int p;
    do_clr();
    send_tok(1'b0, 8'd9); send_tok(1'b0, 8'd0);
    wait_cyc(2);
    p = pop_cnt;
    send_tok(1'b1, 8'd7);
    wait_cyc(7); vec++;
`ifdef RPN_DIV_EN
    if (ERR !== 1'b1 || ERR_CODE !== 2'b11 || LEVEL !== 5'd0) begin
      bad++; $display("FAIL div0: ERR=%b code=%b LEVEL=%0d, expected 1/11/0", ERR, ERR_CODE, LEVEL);
    end
    do_clr();
    exp_q.push_back(8'd4);
    send_tok(1'b0, 8'd9); send_tok(1'b0, 8'd2); send_tok(1'b1, 8'd7);
    wait_cyc(7); vec++;
    if (LEVEL !== 5'd1 || POP_DAT !== 8'd4) begin
      bad++; $display("FAIL div: LEVEL=%0d top=%h, expected 1/04", LEVEL, POP_DAT);
    end
`else
    if (ERR !== 1'b1 || ERR_CODE !== 2'b11 || LEVEL !== 5'd2 || pop_cnt != p) begin
      bad++; $display("FAIL div_illegal: ERR=%b code=%b LEVEL=%0d pops=%0d, expected 1/11/2/0",
                      ERR, ERR_CODE, LEVEL, pop_cnt - p);
    end
`endif
  endtask

  task automatic test_rst_mid();
    do_clr();
    send_tok(1'b0, 8'd1); send_tok(1'b0, 8'd1);
    send_tok(1'b1, 8'd0);      // ADD, abandoned: no expected result
    @(negedge CLK);            // POP_B
    @(negedge CLK);            // GAP
    RST = 1'b1;
    #1; vec++;
    if ({TOK_ACK, PUSH_STB, PUSH_DAT, POP_ACK, RES_DAT, RES_VLD, ERR, ERR_CODE, LEVEL} !== '0) begin
      bad++; $display("FAIL rst_mid: PUSH=%b POP=%b RES=%h/%b ERR=%b LEVEL=%0d, expected all 0",
                      PUSH_STB, POP_ACK, RES_DAT, RES_VLD, ERR, LEVEL);
    end
    @(negedge CLK); RST = 1'b0;
    exp_q.push_back(8'd2);
    send_tok(1'b0, 8'd1); send_tok(1'b0, 8'd1); send_tok(1'b1, 8'd0);
    wait_cyc(7); vec++;
    if (LEVEL !== 5'd1 || POP_DAT !== 8'd2 || RES_DAT !== 8'd2) begin
      bad++; $display("FAIL rst_recover: LEVEL=%0d top=%h RES=%h, expected 1/02/02", LEVEL, POP_DAT, RES_DAT);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_underflow();
    test_err_sticky();
    test_clr_prio();
    test_overflow();
    test_div();
    test_rst_mid();
    wait_cyc(3);
    vec++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL results_pending: %0d results never produced, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
